// File: rtl/stage_m.sv
// Memory/writeback stage: X->M pipeline register, DMEM handshake,
// load alignment and the single-cycle writeback strobe.
module stage_m #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_X,
  input  logic        flush_X,
  input  logic [31:0] inst_X,
  input  logic [31:0] alu_out_X,
  input  logic [31:0] store_data_X,
  input  logic [3:0]  mem_rw_X,
  input  logic [31:0] pc4_X,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] inst_M,
  output logic [31:0] alu_out_M,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_RESP,
    M_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] store_data_M;
  logic [3:0]  mem_rw_M;
  logic [31:0] pc4_M;
  logic        valid_M;
  logic [31:0] load_q;
  logic [31:0] load_aligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_load;
  logic        is_store;
  logic        is_jump;
  logic        cap_valid;
  logic        cap_mem;

  assign is_load  = valid_M && (inst_M[6:0] == OP_LOAD);
  assign is_store = valid_M && (inst_M[6:0] == OP_STORE);
  assign is_jump  = valid_M &&
                    ((inst_M[6:0] == OP_JAL) ||
                     (inst_M[6:0] == OP_JALR));

  assign cap_valid = valid_X && !flush_X;
  assign cap_mem   = cap_valid &&
                     ((inst_X[6:0] == OP_LOAD) ||
                      (inst_X[6:0] == OP_STORE));

  assign stall      = (state == M_REQ) || (state == M_RESP);
  assign dmem_req   = (state == M_REQ);
  assign dmem_addr  = {alu_out_M[31:2], 2'b00};
  assign dmem_we    = (dmem_req && is_store) ? mem_rw_M : 4'b0000;
  assign dmem_wdata = store_data_M << {alu_out_M[1:0], 3'b000};

  assign wb_valid = (state == M_DONE) ||
                    ((state == M_IDLE) && valid_M &&
                     !is_load && !is_store);
  assign wb_data  = is_load ? load_q :
                    is_jump ? pc4_M  : alu_out_M;

  // Pick the addressed byte/half and extend per funct3.
  always_comb begin
    byte_sel     = dmem_rdata[7:0];
    half_sel     = dmem_rdata[15:0];
    load_aligned = 32'h0;
    case (alu_out_M[1:0])
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      2'd3:    byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    if (alu_out_M[1]) half_sel = dmem_rdata[31:16];
    case (inst_M[14:12])
      3'b000:  load_aligned = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_aligned = {24'h0, byte_sel};
      3'b001:  load_aligned = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_aligned = {16'h0, half_sel};
      3'b010:  load_aligned = dmem_rdata;
      default: load_aligned = 32'h0;
    endcase
  end

  // Next-state logic for the DMEM handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:  state_nxt = cap_mem ? M_REQ : M_IDLE;
      M_REQ:   if (dmem_gnt)
                 state_nxt = is_store ? M_DONE : M_RESP;
      M_RESP:  if (dmem_rvalid) state_nxt = M_DONE;
      M_DONE:  state_nxt = cap_mem ? M_REQ : M_IDLE;
      default: state_nxt = M_IDLE;
    endcase
  end

  // State register and load-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= M_IDLE;
      load_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if ((state == M_RESP) && dmem_rvalid)
        load_q <= load_aligned;
    end
  end

  // X->M pipeline register; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_M       <= NOP_INST;
      alu_out_M    <= 32'h0;
      store_data_M <= 32'h0;
      mem_rw_M     <= 4'h0;
      pc4_M        <= 32'h0;
      valid_M      <= 1'b0;
    end else if (!stall) begin
      alu_out_M    <= alu_out_X;
      store_data_M <= store_data_X;
      pc4_M        <= pc4_X;
      if (cap_valid) begin
        inst_M   <= inst_X;
        mem_rw_M <= mem_rw_X;
        valid_M  <= 1'b1;
      end else begin
        inst_M   <= NOP_INST;
        mem_rw_M <= 4'h0;
        valid_M  <= 1'b0;
      end
    end
  end

endmodule
